chess_clock_multi: RTL and testbench

- N-player game clock; successor to the single countdown timer.
- Keeps one mm:ss countdown per player from a shared clock; only the selected player's count runs.
- Adds a Fischer increment on move completion, per-player timeout flags and a sticky game-over.
- Uses a synchronous one-second tick enable instead of a divided clock.
- Drives BCD digits to the existing seven-segment decoders; decoding stays outside this block.

---
 rtl/chess_clock_multi.sv | 222 ++++++++++++++++++++++
 tb/tb_chess_clock_multi.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chess_clock_multi.sv
// -----------------------------------------------------------------------------
// chess_clock_multi
//   N-player game clock. Each player owns an mm:ss countdown held as four BCD
//   digits. Only the player selected by Active counts down, once per second,
//   paced by a prescaler that produces a one-cycle Tick enable. A completed
//   move (Switch) adds a Fischer increment to the mover. A player reaching
//   00:00 raises its Timeout flag; GameOver follows one cycle later, is sticky
//   until reset and freezes every count.
//
//   Optional build macro: CHESS_CLOCK_DELAY_EN
//     Defined   -> simple delay mode: Switch arms a shared delay counter
//                  loaded with INCREMENT_SECONDS. Ticks drain that counter
//                  before they touch the Active player's time.
//     Undefined -> Fischer increment; no delay counter exists.
//
// Ports:
//   clock     in   system clock
//   reset     in   asynchronous active-low reset
//   Run       in   1 = count, 0 = pause (partial second is kept)
//   Active    in   index of the running player; values >= NUM_PLAYERS idle
//   Switch    in   one-cycle pulse: Active player completed a move
//   MinTens   out  BCD minutes tens, player p at [4p+3:4p]
//   MinUnits  out  BCD minutes units
//   SecTens   out  BCD seconds tens
//   SecUnits  out  BCD seconds units
//   Timeout   out  per-player flag
//   GameOver  out  registered, sticky OR of Timeout
//   Tick      out  one-cycle pulse per counted second
// -----------------------------------------------------------------------------
module chess_clock_multi #(
  parameter int NUM_PLAYERS       = 2,
  parameter int CLOCK_FREQUENCY   = 50000000,
  parameter int START_MINUTES     = 5,
  parameter int START_SECONDS     = 0,
  parameter int INCREMENT_SECONDS = 2,
  parameter int PLAYER_BITS       = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     Run,
  input  logic [PLAYER_BITS-1:0]   Active,
  input  logic                     Switch,
  output logic [4*NUM_PLAYERS-1:0] MinTens,
  output logic [4*NUM_PLAYERS-1:0] MinUnits,
  output logic [4*NUM_PLAYERS-1:0] SecTens,
  output logic [4*NUM_PLAYERS-1:0] SecUnits,
  output logic [NUM_PLAYERS-1:0]   Timeout,
  output logic                     GameOver,
  output logic                     Tick
);

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mu;
    logic [3:0] st;
    logic [3:0] su;
  } bcd_t;

  localparam int PW = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
  localparam logic [PW-1:0] TERMINAL = PW'(CLOCK_FREQUENCY - 1);

  // Split into digits at elaboration time; the datapath itself never divides.
  localparam logic [3:0] INC_T = 4'(INCREMENT_SECONDS / 10);
  localparam logic [3:0] INC_U = 4'(INCREMENT_SECONDS % 10);
  localparam bcd_t START_TIME = '{mt: 4'(START_MINUTES / 10), mu: 4'(START_MINUTES % 10),
                                  st: 4'(START_SECONDS / 10), su: 4'(START_SECONDS % 10)};

  // One second off, with BCD borrows; 00:00 is returned unchanged.
  function automatic bcd_t dec_time(input bcd_t t);
    bcd_t r;
    r = t;
    if (t.st != 4'd0 || t.su != 4'd0) begin
      if (t.su != 4'd0) r.su = t.su - 4'd1;
      else begin
        r.su = 4'd9;
        r.st = t.st - 4'd1;
      end
    end else if (t.mt != 4'd0 || t.mu != 4'd0) begin
      r.st = 4'd5;
      r.su = 4'd9;
      if (t.mu != 4'd0) r.mu = t.mu - 4'd1;
      else begin
        r.mu = 4'd9;
        r.mt = t.mt - 4'd1;
      end
    end
    return r;
  endfunction

  // Add the increment with base-10 / base-6 carries; a carry out of 99
  // minutes pins the display at 99:59.
  function automatic bcd_t inc_time(input bcd_t t);
    bcd_t       r;
    logic [4:0] su_sum;
    logic [4:0] st_sum;
    logic       c_sec;
    r      = t;
    su_sum = {1'b0, t.su} + {1'b0, INC_U};
    st_sum = {1'b0, t.st} + {1'b0, INC_T};
    if (su_sum >= 5'd10) begin
      r.su   = 4'(su_sum - 5'd10);
      st_sum = st_sum + 5'd1;
    end else begin
      r.su = su_sum[3:0];
    end
    c_sec = (st_sum >= 5'd6);
    r.st  = c_sec ? 4'(st_sum - 5'd6) : st_sum[3:0];
    if (c_sec) begin
      if (t.mt == 4'd9 && t.mu == 4'd9) r = '{mt: 4'd9, mu: 4'd9, st: 4'd5, su: 4'd9};
      else if (t.mu == 4'd9) begin
        r.mu = 4'd0;
        r.mt = t.mt + 4'd1;
      end else begin
        r.mu = t.mu + 4'd1;
      end
    end
    return r;
  endfunction

  logic [PW-1:0]          r_prescale;
  logic                   r_game_over;
  logic                   w_tick;
  logic [NUM_PLAYERS-1:0] w_sel;
  logic [NUM_PLAYERS-1:0] w_timeout;
  logic                   w_count_en;
  logic                   w_inc_en;

  // Tick fires only while counting, so a freeze also stops the prescaler.
  assign w_tick = Run && !r_game_over && (r_prescale == TERMINAL);

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                     r_prescale <= '0;
    else if (Run && !r_game_over)   r_prescale <= w_tick ? '0 : r_prescale + PW'(1);
  end

  // An out-of-range Active matches no player, which idles ticks and Switch.
  // NOTE: combinational outputs get a default before any conditional write so
  // no path can leave them holding a value, which would infer a latch.
  always_comb begin
    w_sel = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) w_sel[p] = (Active == PLAYER_BITS'(p));
  end

`ifdef CHESS_CLOCK_DELAY_EN
  logic       w_active_valid;
  logic [5:0] r_delay;
  logic       r_armed;

  assign w_active_valid = |w_sel;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_delay <= '0;
      r_armed <= 1'b0;
    end else if (Switch && w_active_valid && !r_game_over) begin
      r_delay <= 6'(INCREMENT_SECONDS);
      r_armed <= ~r_armed;
    end else if (w_tick && w_active_valid && r_delay != 6'd0) begin
      r_delay <= r_delay - 6'd1;
    end
  end

  // The player's own time only runs once the delay has drained.
  assign w_count_en = (r_delay == 6'd0);
  assign w_inc_en   = 1'b0;
`else
  assign w_count_en = 1'b1;
  assign w_inc_en   = 1'b1;
`endif

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
    bcd_t r_time;
    bcd_t w_dec;
    bcd_t w_after_tick;
    bcd_t w_next;
    logic r_flag;
    logic w_tick_p;
    logic w_hit_zero;

    // Decrement first, then increment; landing on 00:00 raises the flag and
    // discards any increment from the same edge.
    always_comb begin
      w_tick_p     = w_tick && w_sel[p] && w_count_en;
      w_dec        = dec_time(r_time);
      w_after_tick = w_tick_p ? w_dec : r_time;
      w_hit_zero   = w_tick_p && (w_dec == '0);
      w_next       = w_after_tick;
      if (!w_hit_zero && w_inc_en && Switch && w_sel[p] && !r_game_over)
        w_next = inc_time(w_after_tick);
    end

    // NOTE: the per-player time registers are reset (not left to power-up)
    // because the START digits must be visible as soon as reset asserts.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_time <= START_TIME;
        r_flag <= 1'b0;
      end else begin
        r_time <= w_next;
        if (w_hit_zero) r_flag <= 1'b1;
      end
    end

    assign MinTens[4*p +: 4]  = r_time.mt;
    assign MinUnits[4*p +: 4] = r_time.mu;
    assign SecTens[4*p +: 4]  = r_time.st;
    assign SecUnits[4*p +: 4] = r_time.su;
    assign w_timeout[p]       = r_flag;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)          r_game_over <= 1'b0;
    else if (|w_timeout) r_game_over <= 1'b1;
  end

  assign Timeout  = w_timeout;
  assign GameOver = r_game_over;
  assign Tick     = w_tick;

endmodule

// File: tb/tb_chess_clock_multi.sv
// -----------------------------------------------------------------------------
// tb_chess_clock_multi
//   Drives chess_clock_multi with directed sequences and random stimulus and
//   compares it every cycle against a reference model that keeps each
//   player's time as a plain integer number of seconds.
// -----------------------------------------------------------------------------
module tb_chess_clock_multi;

  localparam int NP   = 3;
  localparam int PB   = 2;
  localparam int CF   = 4;
  localparam int SM   = 0;
  localparam int SS   = 3;
  localparam int INC  = 2;
  localparam int MAXS = 99 * 60 + 59;

  logic            clock;
  logic            reset;
  logic            Run;
  logic [PB-1:0]   Active;
  logic            Switch;
  logic [4*NP-1:0] MinTens;
  logic [4*NP-1:0] MinUnits;
  logic [4*NP-1:0] SecTens;
  logic [4*NP-1:0] SecUnits;
  logic [NP-1:0]   Timeout;
  logic            GameOver;
  logic            Tick;

  chess_clock_multi #(
    .NUM_PLAYERS      (NP),
    .CLOCK_FREQUENCY  (CF),
    .START_MINUTES    (SM),
    .START_SECONDS    (SS),
    .INCREMENT_SECONDS(INC),
    .PLAYER_BITS      (PB)
  ) u_dut (
    .clock   (clock),
    .reset   (reset),
    .Run     (Run),
    .Active  (Active),
    .Switch  (Switch),
    .MinTens (MinTens),
    .MinUnits(MinUnits),
    .SecTens (SecTens),
    .SecUnits(SecUnits),
    .Timeout (Timeout),
    .GameOver(GameOver),
    .Tick    (Tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_secs [NP];
  logic [NP-1:0] m_to;
  logic        m_go;
  int          m_pre;
  int          m_delay;
  logic        m_last_tick;

  task automatic model_reset();
    for (int p = 0; p < NP; p++) m_secs[p] = SM * 60 + SS;
    m_to    = '0;
    m_go    = 1'b0;
    m_pre   = 0;
    m_delay = 0;
  endtask

  task automatic model_step(input logic run, input int act, input logic sw, input logic tick);
    logic go_next;
    logic do_dec;
    logic hit;
    int   t;
    go_next = m_go | (|m_to);
    if (run && !m_go) m_pre = (m_pre == CF - 1) ? 0 : m_pre + 1;
    if (act < NP) begin
      t      = m_secs[act];
      hit    = 1'b0;
      do_dec = tick;
`ifdef CHESS_CLOCK_DELAY_EN
      do_dec = tick && (m_delay == 0);
      if (sw && !m_go)               m_delay = INC;
      else if (tick && m_delay != 0) m_delay = m_delay - 1;
`endif
      if (do_dec) begin
        if (t > 0) t = t - 1;
        if (t == 0) begin
          hit       = 1'b1;
          m_to[act] = 1'b1;
        end
      end
`ifndef CHESS_CLOCK_DELAY_EN
      if (!hit && sw && !m_go) t = (t + INC > MAXS) ? MAXS : t + INC;
`endif
      m_secs[act] = t;
    end
    m_go = go_next;
  endtask

  function automatic logic [15:0] model_digits(input int p);
    int m;
    int s;
    m = m_secs[p] / 60;
    s = m_secs[p] % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] dut_digits(input int p);
    return {MinTens[4*p +: 4], MinUnits[4*p +: 4], SecTens[4*p +: 4], SecUnits[4*p +: 4]};
  endfunction

  task automatic compare_state();
    for (int p = 0; p < NP; p++)
      check($sformatf("digits_p%0d", p), 64'(dut_digits(p)), 64'(model_digits(p)));
    check("timeout", 64'(Timeout), 64'(m_to));
    check("gameover", 64'(GameOver), 64'(m_go));
  endtask

  // One clock cycle: drive at the falling edge, check Tick before the rising
  // edge, advance the model on it, check state at the next falling edge.
  task automatic cycle(input logic run, input int act, input logic sw);
    logic exp_tick;
    Run    = run;
    Active = PB'(act);
    Switch = sw;
    #1;
    exp_tick = run && !m_go && (m_pre == CF - 1);
    check("tick", 64'(Tick), 64'(exp_tick));
    @(posedge clock);
    model_step(run, act, sw, exp_tick);
    m_last_tick = exp_tick;
    @(negedge clock);
    compare_state();
    Switch = 1'b0;
  endtask

  // Reset asserted between edges; START values must appear without a clock.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    compare_state();
    check("tick_in_reset", 64'(Tick), 64'(0));
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic run_ticks(input int n, input int act);
    int seen;
    seen = 0;
    for (int c = 0; c < n * CF + CF && seen < n; c++) begin
      cycle(1'b1, act, 1'b0);
      if (m_last_tick) seen++;
    end
    check("tick_budget", 64'(seen), 64'(n));
  endtask

  task automatic tick_and_switch(input int act);
    for (int c = 0; c < CF && m_pre != CF - 1; c++) cycle(1'b1, act, 1'b0);
    cycle(1'b1, act, 1'b1);
    check("simultaneous_tick", 64'(m_last_tick), 64'(1));
  endtask

  initial begin
    int resume;
    reset  = 1'b0;
    Run    = 1'b0;
    Active = '0;
    Switch = 1'b0;
    m_last_tick = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);

    // Reset state
    for (int p = 0; p < NP; p++) check($sformatf("reset_p%0d", p), 64'(dut_digits(p)), 64'h0003);
    check("reset_timeout", 64'(Timeout), 64'(0));
    check("reset_gameover", 64'(GameOver), 64'(0));
    check("reset_tick", 64'(Tick), 64'(0));
    reset = 1'b1;

    // Run player 0 down to a flag
    run_ticks(1, 0);
    check("run_t1", 64'(dut_digits(0)), 64'h0002);
    run_ticks(1, 0);
    check("run_t2", 64'(dut_digits(0)), 64'h0001);
    run_ticks(1, 0);
    check("run_t3", 64'(dut_digits(0)), 64'h0000);
    check("run_flag", 64'(Timeout), 64'b001);
    check("run_go_late", 64'(GameOver), 64'(0));
    cycle(1'b1, 0, 1'b0);
    check("run_go", 64'(GameOver), 64'(1));
    check("run_p1_hold", 64'(dut_digits(1)), 64'h0003);
    repeat (8) cycle(1'b1, 0, 1'b1);

    // Mid-cycle reset out of game-over
    async_reset();

`ifndef CHESS_CLOCK_DELAY_EN
    // Increment carry, minute borrow, simultaneous events
    repeat (28) cycle(1'b0, 1, 1'b1);
    check("inc_059", 64'(dut_digits(1)), 64'h0059);
    cycle(1'b0, 1, 1'b1);
    check("inc_carry", 64'(dut_digits(1)), 64'h0101);
    run_ticks(1, 1);
    check("dec_100", 64'(dut_digits(1)), 64'h0100);
    run_ticks(1, 1);
    check("borrow_059", 64'(dut_digits(1)), 64'h0059);
    run_ticks(10, 1);
    check("borrow_049", 64'(dut_digits(1)), 64'h0049);
    run_ticks(39, 1);
    check("at_010", 64'(dut_digits(1)), 64'h0010);
    tick_and_switch(1);
    check("both_011", 64'(dut_digits(1)), 64'h0011);
    run_ticks(10, 1);
    check("at_001", 64'(dut_digits(1)), 64'h0001);
    tick_and_switch(1);
    check("both_zero", 64'(dut_digits(1)), 64'h0000);
    check("both_flag", 64'(Timeout), 64'b010);
    cycle(1'b1, 1, 1'b0);
    async_reset();

    // Saturation at 99:59
    repeat (2998) cycle(1'b0, 2, 1'b1);
    check("sat_9959", 64'(dut_digits(2)), 64'h9959);
    cycle(1'b0, 2, 1'b1);
    check("sat_hold", 64'(dut_digits(2)), 64'h9959);
    async_reset();
`else
    // Delay mode: two ticks drain the delay, the third one counts
    cycle(1'b0, 0, 1'b1);
    run_ticks(1, 0);
    check("delay_t1", 64'(dut_digits(0)), 64'h0003);
    run_ticks(1, 0);
    check("delay_t2", 64'(dut_digits(0)), 64'h0003);
    run_ticks(1, 0);
    check("delay_t3", 64'(dut_digits(0)), 64'h0002);
    async_reset();
`endif

    // Pause mid-second, then resume
    repeat (2) cycle(1'b1, 0, 1'b0);
    repeat (20) cycle(1'b0, 0, 1'b0);
    check("pause_hold", 64'(dut_digits(0)), 64'h0003);
    resume = 0;
    for (int c = 0; c < 2 * CF && !m_last_tick; c++) begin
      cycle(1'b1, 0, 1'b0);
      resume++;
    end
    check("resume_cycles", 64'(resume), 64'(2));
    check("resume_dec", 64'(dut_digits(0)), 64'h0002);

    // Random stimulus: alternating segments with and without moves
    for (int seg = 0; seg < 8; seg++) begin
      for (int c = 0; c < 200; c++) begin
        if ((m_go && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) async_reset();
        cycle($urandom_range(0, 7) != 0, int'($urandom_range(0, 3)),
              (seg % 2 == 0) && ($urandom_range(0, 3) == 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
